// File: rtl/pipeline_types.sv
// Shared pipeline types used by the ME-stage data-memory path.
//
// Contents:
//   DMEM_CNT_W    - width of the responder latency counter (holds 0..15)
//   mem_req_t     - load/store request as presented by the ME stage
//   mem_rsp_t     - response returned to the ME stage
//   dmem_state_e  - responder FSM states
//   dmem_fault    - access-fault predicate evaluated when a request is accepted
package pipeline_types;

    localparam int DMEM_CNT_W = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_e;

    // A request faults when its byte address falls outside the window
    // [base, base+span) or when it enables no byte lane at all. The caller
    // supplies off = addr - base; the below-base test catches the case where
    // that subtraction wrapped.
    function automatic logic dmem_fault(input logic [31:0] addr,
                                        input logic [31:0] off,
                                        input logic [3:0]  be,
                                        input logic [31:0] base,
                                        input logic [32:0] span);
        return (addr < base) || ({1'b0, off} >= span) || (be == 4'b0000);
    endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// Single-port synchronous word SRAM with per-byte write enables.
//
// Ports:
//   clk    in   clock, rising edge
//   en     in   access strobe for this cycle
//   we     in   1 = write enabled lanes, 0 = read
//   be     in   [3:0] byte-lane write enables (lane i = bits [8i+7:8i])
//   addr   in   [AW-1:0] word index
//   wdata  in   [31:0] write data, lane-aligned
//   rdata  out  [31:0] registered read data, updated only by a read access
//
// Contents are deliberately not reset. rdata holds its value between reads,
// which lets the responder present it as a stable response.
module dmem_responder_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int lane = 0; lane < 4; lane++) begin
                    if (be[lane]) begin
                        mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the ME stage's load/store request interface.
// Accepts one request at a time, performs it against an internal byte-enabled
// SRAM and returns a response exactly LATENCY cycles after the accept edge.
//
// Ports:
//   iClk        in   clock, rising edge
//   nRst        in   asynchronous active-low reset
//   iReq_valid  in   ME presents a request
//   oReq_ready  out  request can be accepted this cycle
//   iReq_we     in   1 = store, 0 = load
//   iReq_addr   in   [31:0] byte address, bits [1:0] ignored for indexing
//   iReq_be     in   [3:0] byte-lane enables
//   iReq_wdata  in   [31:0] store data, lane-aligned
//   iAbort      in   ME flush: cancel the transaction in flight
//   oRsp_valid  out  response available
//   iRsp_ready  in   ME consumes the response
//   oRsp_rdata  out  [31:0] load data; 0 for stores and faults
//   oRsp_err    out  access fault for this response
module dmem_responder
    import pipeline_types::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iReq_valid,
    output logic        oReq_ready,
    input  logic        iReq_we,
    input  logic [31:0] iReq_addr,
    input  logic [3:0]  iReq_be,
    input  logic [31:0] iReq_wdata,
    input  logic        iAbort,
    output logic        oRsp_valid,
    input  logic        iRsp_ready,
    output logic [31:0] oRsp_rdata,
    output logic        oRsp_err
);

    localparam int                    AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0]           SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    mem_req_t              req_in;
    mem_rsp_t              rsp;
    logic [31:0]           addr_off;
    logic                  req_fault;

    dmem_state_e           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  accept;
    logic                  access;
    logic                  in_idle;
    logic                  in_resp;

    logic                  we_q;
    logic [AW-1:0]         idx_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic [31:0]           sram_rdata;

    assign req_in    = '{we: iReq_we, addr: iReq_addr, be: iReq_be, wdata: iReq_wdata};
    assign addr_off  = req_in.addr - BASE_ADDR;
    assign req_fault = dmem_fault(req_in.addr, addr_off, req_in.be, BASE_ADDR, SPAN);

    // State and latency counter.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The SRAM access is issued in the last WAIT cycle (counter == 0); its
    // registered read data lands on the same edge that enters RESP, so the
    // SRAM's own cycle of latency is part of the LATENCY count. An abort
    // outranks the access, so an aborted store never reaches the array.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        in_idle = 1'b0;
        in_resp = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                in_idle = 1'b1;
                if (iReq_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (iAbort) begin
                    cnt_d   = '0;
                    state_d = DMEM_IDLE;
                end else if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DMEM_RESP: begin
                in_resp = 1'b1;
                if (iAbort || iRsp_ready) begin
                    state_d = DMEM_IDLE;
                end
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
    end

    // The request is captured on the accept edge together with its fault
    // verdict; a faulting request still runs the full latency.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_in.we;
            idx_q   <= addr_off[AW+1:2];
            be_q    <= req_in.be;
            wdata_q <= req_in.wdata;
            err_q   <= req_fault;
        end
    end

    // A faulting store becomes a harmless read, so memory is left untouched.
    dmem_responder_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_sram (
        .clk  (iClk),
        .en   (access),
        .we   (we_q & ~err_q),
        .be   (be_q),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(sram_rdata)
    );

    // The SRAM read register only changes on an access, so the response
    // stays stable for as long as RESP waits on iRsp_ready.
    always_comb begin
        rsp.rdata = '0;
        rsp.err   = 1'b0;
        if (in_resp) begin
            rsp.err = err_q;
            if (!err_q && !we_q) begin
                rsp.rdata = sram_rdata;
            end
        end
    end

    // Ready is forced low while reset is held even though the state register
    // already reads IDLE, so ME sees no acceptance during reset.
    assign oReq_ready = in_idle & nRst;
    assign oRsp_valid = in_resp;
    assign oRsp_rdata = rsp.rdata;
    assign oRsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking testbench for dmem_responder (DEPTH_WORDS=1024, LATENCY=2,
// BASE_ADDR=0). A table of load/store vectors with hand-computed responses is
// applied in order, followed by hand-written sequences for back-pressure,
// abort and mid-transaction reset.
module tb_dmem_responder;

    localparam int EXP_LAT = 2;
    localparam int TIMEOUT = 20;

    logic        iClk = 1'b0;
    logic        nRst = 1'b0;
    logic        iReq_valid = 1'b0;
    logic        oReq_ready;
    logic        iReq_we = 1'b0;
    logic [31:0] iReq_addr = '0;
    logic [3:0]  iReq_be = '0;
    logic [31:0] iReq_wdata = '0;
    logic        iAbort = 1'b0;
    logic        oRsp_valid;
    logic        iRsp_ready = 1'b0;
    logic [31:0] oRsp_rdata;
    logic        oRsp_err;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vectors[17];

    always #5 iClk = ~iClk;

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (2),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .iClk      (iClk),
        .nRst      (nRst),
        .iReq_valid(iReq_valid),
        .oReq_ready(oReq_ready),
        .iReq_we   (iReq_we),
        .iReq_addr (iReq_addr),
        .iReq_be   (iReq_be),
        .iReq_wdata(iReq_wdata),
        .iAbort    (iAbort),
        .oRsp_valid(oRsp_valid),
        .iRsp_ready(iRsp_ready),
        .oRsp_rdata(oRsp_rdata),
        .oRsp_err  (oRsp_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: timed out after %0d cycles, expected completion", name, TIMEOUT);
    endtask

    // Presents a request and returns just after its accept edge.
    task automatic startRequest(input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata,
                                output bit ok);
        int n;
        iReq_we    = we;
        iReq_addr  = addr;
        iReq_be    = be;
        iReq_wdata = wdata;
        iReq_valid = 1'b1;
        n = 0;
        while (oReq_ready !== 1'b1 && n < TIMEOUT) begin
            @(posedge iClk); #1;
            n++;
        end
        if (oReq_ready !== 1'b1) begin
            timeoutFail("req_accept");
            iReq_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge iClk); #1;
        iReq_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Counts cycles from the accept edge until oRsp_valid is seen.
    task automatic waitResponse(output int lat, output bit ok);
        lat = 0;
        while (oRsp_valid !== 1'b1 && lat < TIMEOUT) begin
            @(posedge iClk); #1;
            lat++;
        end
        ok = (oRsp_valid === 1'b1);
        if (!ok) timeoutFail("rsp_valid");
    endtask

    task automatic consumeResponse();
        iRsp_ready = 1'b1;
        @(posedge iClk); #1;
        iRsp_ready = 1'b0;
    endtask

    // Full transaction: accept, check latency and response, consume.
    task automatic applyStimulus(input vec_t v, input string name);
        bit ok;
        int lat;
        startRequest(v.we, v.addr, v.be, v.wdata, ok);
        if (!ok) return;
        waitResponse(lat, ok);
        if (!ok) return;
        checkOutput({name, " latency"}, 32'(lat), 32'(EXP_LAT));
        checkOutput({name, " rdata"}, oRsp_rdata, v.expRdata);
        checkOutput({name, " err"}, {31'b0, oRsp_err}, {31'b0, v.expErr});
        consumeResponse();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int lat;
        vec_t v;

        //            we    addr          be       wdata          expRdata       expErr
        vectors[0]  = '{1'b1, 32'h0000_0000, 4'hF,    32'h0102_0304, 32'h0,         1'b0};
        vectors[1]  = '{1'b1, 32'h0000_0014, 4'hF,    32'hA5A5_A5A5, 32'h0,         1'b0};
        vectors[2]  = '{1'b1, 32'h0000_0020, 4'hF,    32'h0000_0000, 32'h0,         1'b0};
        vectors[3]  = '{1'b1, 32'h0000_0010, 4'hF,    32'hDEAD_BEEF, 32'h0,         1'b0};
        vectors[4]  = '{1'b0, 32'h0000_0010, 4'hF,    32'h0,         32'hDEAD_BEEF, 1'b0};
        vectors[5]  = '{1'b1, 32'h0000_0010, 4'b0010, 32'h0000_5500, 32'h0,         1'b0};
        vectors[6]  = '{1'b0, 32'h0000_0010, 4'hF,    32'h0,         32'hDEAD_55EF, 1'b0};
        vectors[7]  = '{1'b0, 32'h0000_0013, 4'b0001, 32'h0,         32'hDEAD_55EF, 1'b0};
        vectors[8]  = '{1'b0, 32'h0000_1000, 4'hF,    32'h0,         32'h0,         1'b1};
        vectors[9]  = '{1'b1, 32'h0000_1000, 4'hF,    32'hCAFE_F00D, 32'h0,         1'b1};
        vectors[10] = '{1'b1, 32'h0000_0014, 4'h0,    32'h1111_1111, 32'h0,         1'b1};
        vectors[11] = '{1'b0, 32'h0000_0000, 4'hF,    32'h0,         32'h0102_0304, 1'b0};
        vectors[12] = '{1'b0, 32'h0000_0014, 4'hF,    32'h0,         32'hA5A5_A5A5, 1'b0};
        vectors[13] = '{1'b0, 32'h0000_0010, 4'h0,    32'h0,         32'h0,         1'b1};
        vectors[14] = '{1'b1, 32'h0000_0FFC, 4'hF,    32'h89AB_CDEF, 32'h0,         1'b0};
        vectors[15] = '{1'b0, 32'h0000_0FFC, 4'hF,    32'h0,         32'h89AB_CDEF, 1'b0};
        vectors[16] = '{1'b0, 32'h0000_0020, 4'hF,    32'h0,         32'h0,         1'b0};

        $display("[TB] reset values");
        #12;
        checkOutput("reset ready", {31'b0, oReq_ready}, 32'h0);
        checkOutput("reset rsp_valid", {31'b0, oRsp_valid}, 32'h0);
        checkOutput("reset rdata", oRsp_rdata, 32'h0);
        checkOutput("reset err", {31'b0, oRsp_err}, 32'h0);
        @(posedge iClk); #1;
        nRst = 1'b1;
        @(posedge iClk); #1;
        checkOutput("post-reset ready", {31'b0, oReq_ready}, 32'h1);

        $display("[TB] vector table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vectors[i], $sformatf("vec%0d", i));
        end

        $display("[TB] response back-pressure");
        startRequest(1'b0, 32'h0000_0010, 4'hF, 32'h0, ok);
        if (ok) begin
            waitResponse(lat, ok);
            if (ok) begin
                for (int k = 0; k < 5; k++) begin
                    checkOutput($sformatf("hold%0d rsp_valid", k), {31'b0, oRsp_valid}, 32'h1);
                    checkOutput($sformatf("hold%0d rdata", k), oRsp_rdata, 32'hDEAD_55EF);
                    checkOutput($sformatf("hold%0d ready", k), {31'b0, oReq_ready}, 32'h0);
                    @(posedge iClk); #1;
                end
                consumeResponse();
                checkOutput("hold release ready", {31'b0, oReq_ready}, 32'h1);
                checkOutput("hold release rsp_valid", {31'b0, oRsp_valid}, 32'h0);
            end
        end

        $display("[TB] abort in WAIT");
        startRequest(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678, ok);
        if (ok) begin
            iAbort = 1'b1;
            @(posedge iClk); #1;
            iAbort = 1'b0;
            checkOutput("abort_wait ready", {31'b0, oReq_ready}, 32'h1);
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("abort_wait%0d rsp_valid", k), {31'b0, oRsp_valid}, 32'h0);
                @(posedge iClk); #1;
            end
        end
        v = '{1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'h0, 1'b0};
        applyStimulus(v, "abort_wait reload");

        $display("[TB] abort in RESP");
        startRequest(1'b0, 32'h0000_0014, 4'hF, 32'h0, ok);
        if (ok) begin
            waitResponse(lat, ok);
            if (ok) begin
                checkOutput("abort_resp rdata", oRsp_rdata, 32'hA5A5_A5A5);
                iAbort = 1'b1;
                @(posedge iClk); #1;
                iAbort = 1'b0;
                checkOutput("abort_resp rsp_valid", {31'b0, oRsp_valid}, 32'h0);
                checkOutput("abort_resp ready", {31'b0, oReq_ready}, 32'h1);
            end
        end

        $display("[TB] abort in IDLE is ignored");
        iAbort = 1'b1;
        startRequest(1'b0, 32'h0000_0010, 4'hF, 32'h0, ok);
        iAbort = 1'b0;
        if (ok) begin
            waitResponse(lat, ok);
            if (ok) begin
                checkOutput("abort_idle latency", 32'(lat), 32'(EXP_LAT));
                checkOutput("abort_idle rdata", oRsp_rdata, 32'hDEAD_55EF);
                consumeResponse();
            end
        end

        $display("[TB] reset during WAIT");
        startRequest(1'b0, 32'h0000_0010, 4'hF, 32'h0, ok);
        if (ok) begin
            nRst = 1'b0;
            #1;
            checkOutput("midreset ready", {31'b0, oReq_ready}, 32'h0);
            checkOutput("midreset rsp_valid", {31'b0, oRsp_valid}, 32'h0);
            checkOutput("midreset rdata", oRsp_rdata, 32'h0);
            checkOutput("midreset err", {31'b0, oRsp_err}, 32'h0);
            @(posedge iClk); #1;
            checkOutput("midreset held rsp_valid", {31'b0, oRsp_valid}, 32'h0);
            nRst = 1'b1;
            @(posedge iClk); #1;
            checkOutput("midreset release ready", {31'b0, oReq_ready}, 32'h1);
        end
        v = '{1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_55EF, 1'b0};
        applyStimulus(v, "after_reset load");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
